// File: rtl/mc_controller_ext.sv
// Multicycle MIPS control unit: main-decoder FSM, ALU decoder and PC-enable
// logic, extended with memory wait states, parameter-gated jal/bne, a sticky
// illegal-instruction trap and a busy indication.
module mc_controller_ext #(
  parameter int MEM_WAIT   = 0,
  parameter bit ENABLE_BNE = 1'b1,
  parameter bit ENABLE_JAL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic [1:0] regdst,
  output logic [1:0] memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic       lb,
  output logic [3:0] state,
  output logic       busy,
  output logic       illegal
);

  // Opcodes recognised by the main decoder
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes supported by the ALU decoder
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Last counter value of a memory access state; the access ends when the
  // counter reaches it, so MEM_WAIT = 0 gives single-cycle accesses.
  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_BNE    = 4'd12,
    S_JAL    = 4'd13,
    S_TRAP   = 4'd14
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] cnt_reg;
  logic [3:0] cnt_next;
  logic       illegal_reg;
  logic       lbf_reg;
  logic       lbf_next;

  logic       pcwrite;
  logic       branch_eq;
  logic       branch_ne;
  logic       wait_last;
  logic       strobe_ok;
  logic       funct_ok;

  // Final cycle of a memory access; strobes and busy are suppressed while
  // reset is held so an aborted access never fires a write or a PC update.
  assign wait_last = (cnt_reg == WAIT_LIMIT);
  assign strobe_ok = wait_last & ~reset;

  // R-type instructions outside the supported function set are trapped
  assign funct_ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                    (funct == FN_OR)  || (funct == FN_SLT);

  // State, wait counter, sticky trap flag and byte-load flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= S_FETCH;
      cnt_reg     <= 4'd0;
      illegal_reg <= 1'b0;
      lbf_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      illegal_reg <= illegal_reg | (state_next == S_TRAP);
      lbf_reg     <= lbf_next;
    end
  end

  // Next-state logic and per-state control outputs
  always_comb begin
    state_next = state_reg;
    cnt_next   = 4'd0;
    lbf_next   = lbf_reg;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    regdst     = 2'b00;
    memtoreg   = 2'b00;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b010;
    pcsrc      = 2'b00;
    pcwrite    = 1'b0;
    branch_eq  = 1'b0;
    branch_ne  = 1'b0;
    busy       = 1'b0;

    case (state_reg)
      S_FETCH: begin
        alusrcb = 2'b01;
        busy    = ~wait_last & ~reset;
        irwrite = strobe_ok;
        pcwrite = strobe_ok;
        if (wait_last) state_next = S_DECODE;
        else           cnt_next   = cnt_reg + 4'd1;
      end

      S_DECODE: begin
        alusrcb  = 2'b11;
        lbf_next = (op == OP_LB);
        case (op)
          OP_LW, OP_SW, OP_LB: state_next = S_MEMADR;
          OP_RTYPE:            state_next = funct_ok ? S_REX : S_TRAP;
          OP_BEQ:              state_next = S_BEQ;
          OP_BNE:              state_next = ENABLE_BNE ? S_BNE : S_TRAP;
          OP_ADDI:             state_next = S_ADDIEX;
          OP_J:                state_next = S_JUMP;
          OP_JAL:              state_next = ENABLE_JAL ? S_JAL : S_TRAP;
          default:             state_next = S_TRAP;
        endcase
      end

      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        iord = 1'b1;
        busy = ~wait_last & ~reset;
        if (wait_last) state_next = S_MEMWB;
        else           cnt_next   = cnt_reg + 4'd1;
      end

      S_MEMWB: begin
        memtoreg   = 2'b01;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        iord     = 1'b1;
        busy     = ~wait_last & ~reset;
        memwrite = strobe_ok;
        if (wait_last) state_next = S_FETCH;
        else           cnt_next   = cnt_reg + 4'd1;
      end

      S_REX: begin
        alusrca = 1'b1;
        case (funct)
          FN_ADD:  alucontrol = 3'b010;
          FN_SUB:  alucontrol = 3'b110;
          FN_AND:  alucontrol = 3'b000;
          FN_OR:   alucontrol = 3'b001;
          FN_SLT:  alucontrol = 3'b111;
          default: alucontrol = 3'b010;
        endcase
        state_next = S_RWB;
      end

      S_RWB: begin
        regdst     = 2'b01;
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_BEQ: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch_eq  = 1'b1;
        state_next = S_FETCH;
      end

      S_BNE: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        branch_ne  = 1'b1;
        state_next = S_FETCH;
      end

      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_IWB;
      end

      S_IWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end

      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        state_next = S_FETCH;
      end

      // The PC was already advanced in FETCH, so the link value is PC+4
      S_JAL: begin
        regdst     = 2'b10;
        memtoreg   = 2'b10;
        regwrite   = 1'b1;
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        state_next = S_FETCH;
      end

      // Held here until reset; every strobe stays low
      S_TRAP: begin
        state_next = S_TRAP;
      end

      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // PC enable combines unconditional writes with taken branches
  assign pcen    = pcwrite | (branch_eq & zero) | (branch_ne & ~zero);
  assign lb      = lbf_reg;
  assign state   = state_reg;
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_mc_controller_ext.sv
// Testbench for mc_controller_ext: three instances with different wait-state
// and enable settings, directed plus random instruction streams checked cycle
// by cycle against a phase-list reference model.
module tb_mc_controller_ext;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic [23:0] obs_w [3];
  logic [1:0]  sel;
  logic [23:0] obs;

  int checks = 0;
  int passed = 0;
  int ph[$];
  logic [5:0] ro, rf;
  bit rz;

  always #5 clk = ~clk;

  // Instance 0: no waits; 1: two waits; 2: three waits, jal/bne disabled
  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic       memwrite, iord, irwrite, regwrite, alusrca, pcen, lb, busy, illegal;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic [3:0] state;
    mc_controller_ext #(
      .MEM_WAIT  (gi == 0 ? 0 : (gi == 1 ? 2 : 3)),
      .ENABLE_BNE(gi != 2),
      .ENABLE_JAL(gi != 2)
    ) u_dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
      .alusrcb(alusrcb), .alucontrol(alucontrol), .pcen(pcen), .pcsrc(pcsrc),
      .lb(lb), .state(state), .busy(busy), .illegal(illegal)
    );
    assign obs_w[gi] = {state, memwrite, iord, irwrite, regdst, memtoreg, regwrite,
                        alusrca, alusrcb, alucontrol, pcen, pcsrc, lb, busy, illegal};
  end

  assign obs = obs_w[sel];

  function automatic int mw_of(logic [1:0] s);
    return (s == 2'd0) ? 0 : ((s == 2'd1) ? 2 : 3);
  endfunction

  function automatic bit ext_en(logic [1:0] s);
    return s != 2'd2;
  endfunction

  // Expected output word for one cycle of a given state
  function automatic logic [23:0] model(int code, bit last, logic [5:0] o, logic [5:0] f, bit z);
    logic [3:0] st = 4'(code);
    logic mw = 0, io = 0, ir = 0, rw = 0, sa = 0, pe = 0, l = 0, b = 0, il = 0;
    logic [1:0] rd = 0, mt = 0, sb = 0, ps = 0;
    logic [2:0] ac = 3'b010;
    case (code)
      0:  begin sb = 2'b01; ir = last; pe = last; b = !last; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin io = 1; b = !last; end
      4:  begin mt = 2'b01; rw = 1; l = (o == OP_LB); end
      5:  begin io = 1; mw = last; b = !last; end
      6:  begin
            sa = 1;
            if (f == 6'b100010) ac = 3'b110;
            else if (f == 6'b100100) ac = 3'b000;
            else if (f == 6'b100101) ac = 3'b001;
            else if (f == 6'b101010) ac = 3'b111;
          end
      7:  begin rd = 2'b01; rw = 1; end
      8:  begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin ps = 2'b10; pe = 1; end
      12: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = !z; end
      13: begin rd = 2'b10; mt = 2'b10; rw = 1; ps = 2'b10; pe = 1; end
      14: il = 1;
      default: ;
    endcase
    return {st, mw, io, ir, rd, mt, rw, sa, sb, ac, pe, ps, l, b, il};
  endfunction

  // Sequence of states an instruction walks through on the selected instance
  task automatic build_phases(logic [5:0] o, logic [5:0] f);
    ph.delete();
    ph.push_back(0);
    ph.push_back(1);
    if (o == OP_LW || o == OP_LB) begin ph.push_back(2); ph.push_back(3); ph.push_back(4); end
    else if (o == OP_SW) begin ph.push_back(2); ph.push_back(5); end
    else if (o == OP_R && (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                           f == 6'b100101 || f == 6'b101010)) begin
      ph.push_back(6); ph.push_back(7);
    end
    else if (o == OP_BEQ) ph.push_back(8);
    else if (o == OP_BNE && ext_en(sel)) ph.push_back(12);
    else if (o == OP_ADDI) begin ph.push_back(9); ph.push_back(10); end
    else if (o == OP_J) ph.push_back(11);
    else if (o == OP_JAL && ext_en(sel)) ph.push_back(13);
    else ph.push_back(14);
  endtask

  task automatic check(string tag, logic [23:0] o_v, logic [23:0] e_v);
    checks++;
    assert (o_v === e_v) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o_v, e_v);
  endtask

  // Async reset: outputs must drop immediately, then release after a clock
  task automatic do_reset();
    logic [23:0] o_v;
    reset = 1'b1;
    #2;
    o_v = obs;
    check($sformatf("reset i%0d", sel),
          {15'd0, o_v[23:20], o_v[19], o_v[17], o_v[12], o_v[5], o_v[1], o_v[0]}, 24'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Run one instruction (or only its first max_cyc cycles when max_cyc > 0)
  task automatic run_instr(logic [5:0] o, logic [5:0] f, bit z, int max_cyc);
    int n_done = 0;
    op = o; funct = f; zero = z;
    build_phases(o, f);
    foreach (ph[p]) begin
      int code = ph[p];
      int len = (code == 0 || code == 3 || code == 5) ? mw_of(sel) + 1 : ((code == 14) ? 11 : 1);
      for (int c = 0; c < len; c++) begin
        logic [23:0] e_v;
        logic [23:0] o_v;
        if (max_cyc > 0 && n_done == max_cyc) return;
        @(negedge clk);
        e_v = model(code, c == len - 1, o, f, z);
        o_v = obs;
        if (code != 4) begin e_v[2] = 1'b0; o_v[2] = 1'b0; end
        check($sformatf("i%0d op=%b fn=%b z=%0d st=%0d cyc=%0d", sel, o, f, z, code, c), o_v, e_v);
        @(posedge clk);
        #1;
        n_done++;
      end
    end
  endtask

  task automatic pick(output logic [5:0] o, output logic [5:0] f);
    int k = $urandom_range(0, 14);
    f = 6'($urandom);
    case (k)
      0: o = OP_LW;
      1: o = OP_SW;
      2: o = OP_LB;
      3: begin o = OP_R; f = 6'b100000; end
      4: begin o = OP_R; f = 6'b100010; end
      5: begin o = OP_R; f = 6'b100100; end
      6: begin o = OP_R; f = 6'b100101; end
      7: begin o = OP_R; f = 6'b101010; end
      8: o = OP_R;
      9: o = OP_BEQ;
      10: o = OP_BNE;
      11: o = OP_ADDI;
      12: o = OP_J;
      13: o = OP_JAL;
      default: o = 6'($urandom);
    endcase
  endtask

  task automatic random_run(int n);
    for (int i = 0; i < n; i++) begin
      pick(ro, rf);
      rz = 1'($urandom);
      run_instr(ro, rf, rz, 0);
      if (ph[ph.size() - 1] == 14) do_reset();
    end
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; sel = 2'd0;

    // Instance 0: no wait states
    do_reset();
    run_instr(OP_LW, 6'd0, 1'b0, 0);
    run_instr(OP_BEQ, 6'd0, 1'b1, 0);
    run_instr(OP_BNE, 6'd0, 1'b1, 0);
    run_instr(OP_BNE, 6'd0, 1'b0, 0);
    run_instr(OP_JAL, 6'd0, 1'b0, 0);
    run_instr(OP_R, 6'b101010, 1'b0, 0);
    run_instr(OP_LB, 6'd0, 1'b0, 0);
    run_instr(OP_LW, 6'd0, 1'b0, 0);
    run_instr(OP_ADDI, 6'd0, 1'b0, 0);
    run_instr(OP_J, 6'd0, 1'b0, 0);
    run_instr(OP_R, 6'b000111, 1'b0, 0);
    do_reset();
    random_run(40);

    // Instance 1: two wait states
    sel = 2'd1;
    do_reset();
    run_instr(OP_SW, 6'd0, 1'b0, 0);
    run_instr(OP_LB, 6'd0, 1'b1, 0);
    random_run(40);

    // Instance 2: three wait states, jal/bne disabled
    sel = 2'd2;
    do_reset();
    run_instr(OP_JAL, 6'd0, 1'b0, 0);
    do_reset();
    run_instr(OP_LW, 6'd0, 1'b0, 8);
    do_reset();
    run_instr(OP_LW, 6'd0, 1'b0, 0);
    run_instr(OP_BNE, 6'd0, 1'b0, 0);
    do_reset();
    random_run(30);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
